// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 field widths, rounding modes and float-to-int conversion types
package fpu_pkg;
    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_OVF} cls_e;

    typedef struct packed {
        logic        s;
        logic [2:0]  rm;
        logic [31:0] mag;
        logic        guard;
        logic        sticky;
        cls_e        cls;
    } s1_t;
endpackage

// File: rtl/ftoi_round.sv
// ftoi_round: rounds a de-normalised magnitude, applies the sign and saturates
module ftoi_round import fpu_pkg::*; #(
    parameter bit NAN_POS_SAT = 1'b1
) (
    input  logic        s,
    input  logic [2:0]  rm,
    input  logic [31:0] mag,
    input  logic        guard,
    input  logic        sticky,
    input  cls_e        cls,
    output logic [31:0] y,
    output logic        invalid,
    output logic        inexact
);
    logic        inc;
    logic [32:0] r;
    logic        ovf;

    // pick the round-up decision, detect range overflow, then select the final word
    always_comb begin
        inc = rm == RM_RTZ ? 1'b0 :
              rm == RM_RDN ? s & (guard | sticky) :
              rm == RM_RUP ? ~s & (guard | sticky) :
              rm == RM_RMM ? guard :
              guard & (sticky | mag[0]);
        r = {1'b0, mag} + {32'b0, inc};
        ovf = s ? r > {1'b0, INT_MIN} : r > {1'b0, INT_MAX};
        invalid = cls != CLS_NORM || ovf;
        y = cls == CLS_NAN ? (NAN_POS_SAT ? INT_MAX : INT_MIN) :
            invalid ? (s ? INT_MIN : INT_MAX) :
            s ? -r[31:0] : r[31:0];
        inexact = ~invalid & (guard | sticky);
    end
endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage binary32 to signed int32 converter with valid/ready on both sides
module ftoi_pipe import fpu_pkg::*; #(
    parameter bit NAN_POS_SAT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_invalid,
    output logic        out_inexact
);
    // exponent at which the significand's lsb has weight 1, and the first exponent that overflows
    localparam logic [7:0] E_SHL = 8'(BIAS + MAN_W);
    localparam logic [7:0] E_OVF = 8'(BIAS + 31);
    localparam logic [7:0] E_MAX = {EXP_W{1'b1}};
    localparam logic [7:0] E_FAR = E_SHL - 8'd26;

    s1_t         s1_n, s1_d, s1_q;
    logic        s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
    logic [31:0] y_d, y_q, rnd_y;
    logic        inv_d, inv_q, inex_d, inex_q, rnd_inv, rnd_inex;
    logic        en1, en2;
    logic [7:0]  e;
    logic [22:0] frac;
    logic [23:0] m;
    logic [49:0] ext;
    logic [31:0] lsh;

    // unpack the operand and de-normalise the significand into magnitude, guard and sticky
    always_comb begin
        e = in_a[30:23];
        frac = in_a[22:0];
        m = {1'b1, frac};
        ext = {m, 26'b0} >> (e < E_FAR ? 6'd26 : 6'(E_SHL - e));
        lsh = 32'(m) << 4'(e - E_SHL);
        s1_n = '{s: in_a[31], rm: in_rm, mag: '0, guard: 1'b0, sticky: 1'b0, cls: CLS_NORM};
        if (e == E_MAX) s1_n.cls = frac != '0 ? CLS_NAN : CLS_INF;
        else if (e > E_OVF || (e == E_OVF && (!in_a[31] || frac != '0))) s1_n.cls = CLS_OVF;
        else if (e >= E_SHL) s1_n.mag = lsh;
        else if (e != '0) begin
            s1_n.mag = 32'(ext[49:26]);
            s1_n.guard = ext[25];
            s1_n.sticky = |ext[24:0];
        end
    end

    ftoi_round #(.NAN_POS_SAT(NAN_POS_SAT)) u_round (
        .s      (s1_q.s),
        .rm     (s1_q.rm),
        .mag    (s1_q.mag),
        .guard  (s1_q.guard),
        .sticky (s1_q.sticky),
        .cls    (s1_q.cls),
        .y      (rnd_y),
        .invalid(rnd_inv),
        .inexact(rnd_inex)
    );

    // each stage advances when the one after it can take its item, otherwise it holds
    always_comb begin
        en2 = ~s2_valid_q | out_ready;
        en1 = ~s1_valid_q | en2;
        s1_valid_d = en1 ? in_valid : s1_valid_q;
        s1_d = en1 && in_valid ? s1_n : s1_q;
        s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
        y_d = en2 && s1_valid_q ? rnd_y : y_q;
        inv_d = en2 && s1_valid_q ? rnd_inv : inv_q;
        inex_d = en2 && s1_valid_q ? rnd_inex : inex_q;
    end

    // pipeline registers; reset discards in-flight items and zeroes the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q <= '0;
            y_q <= '0;
            inv_q <= 1'b0;
            inex_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q <= s1_d;
            y_q <= y_d;
            inv_q <= inv_d;
            inex_q <= inex_d;
        end
    end

    assign in_ready = en1;
    assign out_valid = s2_valid_q;
    assign out_y = y_q;
    assign out_invalid = inv_q;
    assign out_inexact = inex_q;
endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: vector table, backpressure, reset and random checks of ftoi_pipe
module tb_ftoi_pipe;
    import fpu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  rm;
        logic [31:0] y;
        logic        inv;
        logic        inex;
        int          cyc;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_a = '0, out_y;
    logic [2:0]  in_rm = '0;
    logic        out_invalid, out_inexact;

    int   total = 0, bad = 0, cyc = 0;
    bit   chk_lat = 0, rnd_on = 0, saw_nr = 0, stall_prev = 0;
    ent_t q[$];
    ent_t cur;
    ent_t tbl[22];
    logic [33:0] held;

    ftoi_pipe #(.NAN_POS_SAT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_invalid(out_invalid), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) if (rnd_on) begin
        #1;
        out_ready = ($urandom % 4) != 0;
    end

    // reference: value of the float as a real number, rounded with plain arithmetic
    function automatic real pow2(input int k);
        real p = 1.0;
        for (int i = 0; i < (k < 0 ? -k : k); i++) p = k < 0 ? p * 0.5 : p * 2.0;
        return p;
    endfunction

    function automatic ent_t model(input logic [31:0] a, input logic [2:0] rm);
        ent_t r;
        real v, fl, fr, rv;
        longint li;
        r.a = a; r.rm = rm; r.cyc = 0; r.inv = 1'b0; r.inex = 1'b0; r.y = '0;
        if (a[30:23] == 8'hFF) begin
            r.inv = 1'b1;
            r.y = (a[22:0] != 0 || !a[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
            return r;
        end
        v = a[30:23] == 0 ? 0.0 : (1.0 + real'(a[22:0]) / 8388608.0) * pow2(int'(a[30:23]) - 127);
        if (a[31]) v = -v;
        if (v >= 4294967296.0 || v <= -4294967296.0) begin
            r.inv = 1'b1;
            r.y = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return r;
        end
        fl = $floor(v);
        fr = v - fl;
        case (rm)
            3'd1: rv = v < 0.0 ? $ceil(v) : fl;
            3'd2: rv = fl;
            3'd3: rv = $ceil(v);
            3'd4: rv = fr < 0.5 ? fl : fr > 0.5 ? fl + 1.0 : (v < 0.0 ? fl : fl + 1.0);
            default: rv = fr < 0.5 ? fl : fr > 0.5 ? fl + 1.0 : ((longint'(fl) % 2 == 0) ? fl : fl + 1.0);
        endcase
        if (rv > 2147483647.0 || rv < -2147483648.0) begin
            r.inv = 1'b1;
            r.y = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            li = longint'(rv);
            r.y = li[31:0];
            r.inex = rv != v;
        end
        return r;
    endfunction

    function automatic ent_t mk(input logic [31:0] a, input logic [2:0] rm, input logic [31:0] y,
                                input logic inv, input logic inex);
        ent_t r;
        r.a = a; r.rm = rm; r.y = y; r.inv = inv; r.inex = inex; r.cyc = 0;
        return r;
    endfunction

    function automatic logic [31:0] rand_a();
        logic [7:0] e;
        if ($urandom % 8 == 0) return $urandom;
        e = 8'(110 + $urandom % 55);
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // scoreboard: record accepted inputs, compare transferred outputs, watch held values
    always @(negedge clk) begin
        ent_t x;
        if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out y=%h inv=%b inex=%b", out_y, out_invalid, out_inexact);
            end else begin
                x = q.pop_front();
                if ({out_y, out_invalid, out_inexact} !== {x.y, x.inv, x.inex}) begin
                    bad++;
                    $display("FAIL result a=%h rm=%0d got y=%h inv=%b inex=%b want y=%h inv=%b inex=%b",
                             x.a, x.rm, out_y, out_invalid, out_inexact, x.y, x.inv, x.inex);
                end
                if (chk_lat) begin
                    total++;
                    if (cyc - x.cyc != 2) begin
                        bad++;
                        $display("FAIL latency a=%h got=%0d want=2", x.a, cyc - x.cyc);
                    end
                end
            end
        end
        if (stall_prev && out_valid) begin
            total++;
            if ({out_y, out_invalid, out_inexact} !== held) begin
                bad++;
                $display("FAIL hold got=%h want=%h", {out_y, out_invalid, out_inexact}, held);
            end
        end
        stall_prev = out_valid && !out_ready;
        held = {out_y, out_invalid, out_inexact};
        if (!in_ready) saw_nr = 1;
        if (in_valid && in_ready) begin
            x = cur;
            x.cyc = cyc;
            q.push_back(x);
        end
    end

    task automatic send(input ent_t e);
        int n = 0;
        bit acc = 0;
        in_a = e.a; in_rm = e.rm; cur = e; in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout a=%h got=stuck want=accepted", e.a);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
    endtask

    initial begin
        tbl[0]  = mk(32'h3FC0_0000, RM_RNE, 32'd2, 0, 1);
        tbl[1]  = mk(32'h4020_0000, RM_RNE, 32'd2, 0, 1);
        tbl[2]  = mk(32'h4020_0000, RM_RUP, 32'd3, 0, 1);
        tbl[3]  = mk(32'hBFC0_0000, RM_RTZ, 32'hFFFF_FFFF, 0, 1);
        tbl[4]  = mk(32'hC2F6_0000, RM_RNE, 32'hFFFF_FF85, 0, 0);
        tbl[5]  = mk(32'h0040_0000, RM_RNE, 32'd0, 0, 0);
        tbl[6]  = mk(32'h3F00_0000, RM_RNE, 32'd0, 0, 1);
        tbl[7]  = mk(32'h3F00_0000, RM_RMM, 32'd1, 0, 1);
        tbl[8]  = mk(32'h4F00_0000, RM_RNE, 32'h7FFF_FFFF, 1, 0);
        tbl[9]  = mk(32'hCF00_0000, RM_RNE, 32'h8000_0000, 0, 0);
        tbl[10] = mk(32'h7FC0_0000, RM_RNE, 32'h7FFF_FFFF, 1, 0);
        tbl[11] = mk(32'hFF80_0000, RM_RNE, 32'h8000_0000, 1, 0);
        tbl[12] = mk(32'h7F80_0000, RM_RTZ, 32'h7FFF_FFFF, 1, 0);
        tbl[13] = mk(32'h8000_0000, RM_RNE, 32'd0, 0, 0);
        tbl[14] = mk(32'hBFC0_0000, RM_RDN, 32'hFFFF_FFFE, 0, 1);
        tbl[15] = mk(32'h3FC0_0000, RM_RDN, 32'd1, 0, 1);
        tbl[16] = mk(32'h4EFF_FFFF, RM_RNE, 32'h7FFF_FF80, 0, 0);
        tbl[17] = mk(32'hCF00_0001, RM_RNE, 32'h8000_0000, 1, 0);
        tbl[18] = mk(32'h3E80_0000, RM_RUP, 32'd1, 0, 1);
        tbl[19] = mk(32'hBE80_0000, RM_RUP, 32'd0, 0, 1);
        tbl[20] = mk(32'h4020_0000, 3'b111, 32'd2, 0, 1);
        tbl[21] = mk(32'h3FC0_0000, 3'b101, 32'd2, 0, 1);

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_flags", 64'({out_invalid, out_inexact}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        chk_lat = 1;
        for (int i = 0; i < 22; i++) send(tbl[i]);
        drain();
        chk_lat = 0;

        saw_nr = 0;
        fork
            for (int i = 0; i < 6; i++) send(model(rand_a(), 3'($urandom)));
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_drop", 64'(saw_nr), 64'd1);

        out_ready = 1'b0;
        send(model(32'h4040_0000, RM_RNE));
        send(model(32'hC0A0_0000, RM_RNE));
        check("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_y", 64'(out_y), 64'd0);
        check("midrst_flags", 64'({out_invalid, out_inexact}), 64'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        chk_lat = 1;
        send(model(32'h42F6_0000, RM_RTZ));
        drain();
        chk_lat = 0;

        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 3 == 0) begin
                @(posedge clk);
                #1;
            end
            send(model(rand_a(), 3'($urandom)));
        end
        rnd_on = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
